// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with bubbles, freeze and an illegal-opcode counter.
module pipelined_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 8,
  parameter int JALR_EN  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                flush,
  input  logic                freeze,
  output logic                id_jump,
  output logic                id_jr,
  output logic                id_reg1,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic                ex_branch,
  output logic                ex_bne,
  output logic                ex_jal,
  output logic                ex_illegal,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic                ex_mem_read,
  output logic                mem_read,
  output logic                mem_write,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic                wb_jal,
  output logic [CNT_W-1:0]    illegal_cnt
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jr;
    logic       reg1;
    logic       jal;
    logic       illegal;
    logic [1:0] alu_op;
  } dec_t;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               branch;
    logic               bne;
    logic               jal;
    logic               illegal;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
  } idex_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic jal;
  } exmem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic jal;
  } memwb_t;

  function automatic logic [ALUOP_W-1:0] aluop_ext(input logic [1:0] code);
    return ALUOP_W'(code);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic       w_hi_ok;
  logic [5:0] w_op6;
  dec_t       w_dec;
  idex_t      w_idex_next;
  idex_t      r_idex_p0;
  exmem_t     r_exmem_p1;
  memwb_t     r_memwb_p2;
  logic [CNT_W-1:0] r_cnt;

  // Any set bit above [5:0] makes the opcode illegal.
  if (OPCODE_W > 6) begin : g_hi
    assign w_hi_ok = ~|opcode[OPCODE_W-1:6];
  end else begin : g_nohi
    assign w_hi_ok = 1'b1;
  end

  assign w_op6 = opcode[5:0];

  always_comb begin
    w_dec = '0;
    unique case (w_op6)
      6'b000000: begin w_dec.reg_dst = 1'b1; w_dec.reg_write = 1'b1; w_dec.alu_op = 2'd2; end
      6'b100011: begin
        w_dec.alu_src = 1'b1; w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write = 1'b1; w_dec.mem_read = 1'b1;
      end
      6'b101011: begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
      6'b000100: begin w_dec.branch = 1'b1; w_dec.alu_op = 2'd1; end
      6'b100000: begin w_dec.bne = 1'b1; w_dec.alu_op = 2'd1; end
      6'b000001: begin w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1; end
      6'b000010: w_dec.jump = 1'b1;
      6'b000011: begin w_dec.jr = 1'b1; w_dec.reg1 = 1'b1; end
      6'b000111: begin w_dec.jump = 1'b1; w_dec.jal = 1'b1; w_dec.reg_write = 1'b1; end
      6'b001111: begin
        if (JALR_EN != 0) begin
          w_dec.jr = 1'b1; w_dec.reg1 = 1'b1;
          w_dec.jal = 1'b1; w_dec.reg_write = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      default:   w_dec.illegal = 1'b1;
    endcase
    if (!w_hi_ok) begin
      w_dec = '0;
      w_dec.illegal = 1'b1;
    end
    if (!id_valid) w_dec = '0;
  end

  always_comb begin
    w_idex_next            = '0;
    w_idex_next.reg_dst    = w_dec.reg_dst;
    w_idex_next.alu_src    = w_dec.alu_src;
    w_idex_next.branch     = w_dec.branch;
    w_idex_next.bne        = w_dec.bne;
    w_idex_next.jal        = w_dec.jal;
    w_idex_next.illegal    = w_dec.illegal;
    w_idex_next.mem_read   = w_dec.mem_read;
    w_idex_next.mem_write  = w_dec.mem_write;
    w_idex_next.reg_write  = w_dec.reg_write;
    w_idex_next.mem_to_reg = w_dec.mem_to_reg;
    w_idex_next.alu_op     = aluop_ext(w_dec.alu_op);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex_p0  <= '0;
      r_exmem_p1 <= '0;
      r_memwb_p2 <= '0;
      r_cnt      <= '0;
    end else if (!freeze) begin
      // ID/EX -> EX/MEM -> MEM/WB; a stall or flush injects a bubble at ID/EX only
      r_idex_p0  <= (stall || flush) ? '0 : w_idex_next;
      r_exmem_p1 <= '{mem_read:   r_idex_p0.mem_read,
                      mem_write:  r_idex_p0.mem_write,
                      reg_write:  r_idex_p0.reg_write,
                      mem_to_reg: r_idex_p0.mem_to_reg,
                      jal:        r_idex_p0.jal};
      r_memwb_p2 <= '{reg_write:  r_exmem_p1.reg_write,
                      mem_to_reg: r_exmem_p1.mem_to_reg,
                      jal:        r_exmem_p1.jal};
      if (w_dec.illegal && !stall && !flush) r_cnt <= sat_inc(r_cnt);
    end
  end

  assign id_jump       = w_dec.jump;
  assign id_jr         = w_dec.jr;
  assign id_reg1       = w_dec.reg1;
  assign ex_reg_dst    = r_idex_p0.reg_dst;
  assign ex_alu_src    = r_idex_p0.alu_src;
  assign ex_branch     = r_idex_p0.branch;
  assign ex_bne        = r_idex_p0.bne;
  assign ex_jal        = r_idex_p0.jal;
  assign ex_illegal    = r_idex_p0.illegal;
  assign ex_alu_op     = r_idex_p0.alu_op;
  assign ex_mem_read   = r_idex_p0.mem_read;
  assign mem_read      = r_exmem_p1.mem_read;
  assign mem_write     = r_exmem_p1.mem_write;
  assign wb_reg_write  = r_memwb_p2.reg_write;
  assign wb_mem_to_reg = r_memwb_p2.mem_to_reg;
  assign wb_jal        = r_memwb_p2.jal;
  assign illegal_cnt   = r_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: four parameter variants share
// control inputs; expectations are queued per clock edge and checked by a monitor.
module tb_pipelined_control_unit;

  localparam int F_JUMP = 0, F_JR = 1, F_REG1 = 2, F_REG_DST = 3, F_ALU_SRC = 4,
                 F_BRANCH = 5, F_BNE = 6, F_EX_JAL = 7, F_ILLEGAL = 8, F_ALU_OP = 9,
                 F_EX_MEM_READ = 10, F_MEM_READ = 11, F_MEM_WRITE = 12,
                 F_WB_REG_WRITE = 13, F_WB_MEM_TO_REG = 14, F_WB_JAL = 15, F_CNT = 16;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b100000, OP_ADDI = 6'b000001,
                         OP_J = 6'b000010, OP_JR = 6'b000011, OP_JAL = 6'b000111,
                         OP_JALR = 6'b001111, OP_BAD = 6'b111111, OP_BAD2 = 6'b010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, stall, flush, freeze;
  logic [5:0] op0, op1, op2;
  logic [7:0] op3;

  logic [3:0] w_id_jump, w_id_jr, w_id_reg1, w_ex_reg_dst, w_ex_alu_src, w_ex_branch,
              w_ex_bne, w_ex_jal, w_ex_illegal, w_ex_mem_read, w_mem_read, w_mem_write,
              w_wb_reg_write, w_wb_mem_to_reg, w_wb_jal;
  logic [1:0] w_alu_op [4];
  logic [7:0] w_cnt0, w_cnt1, w_cnt3;
  logic [1:0] w_cnt2;

  pipelined_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(8), .JALR_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(op0), .stall(stall),
    .flush(flush), .freeze(freeze), .id_jump(w_id_jump[0]), .id_jr(w_id_jr[0]),
    .id_reg1(w_id_reg1[0]), .ex_reg_dst(w_ex_reg_dst[0]), .ex_alu_src(w_ex_alu_src[0]),
    .ex_branch(w_ex_branch[0]), .ex_bne(w_ex_bne[0]), .ex_jal(w_ex_jal[0]),
    .ex_illegal(w_ex_illegal[0]), .ex_alu_op(w_alu_op[0]), .ex_mem_read(w_ex_mem_read[0]),
    .mem_read(w_mem_read[0]), .mem_write(w_mem_write[0]), .wb_reg_write(w_wb_reg_write[0]),
    .wb_mem_to_reg(w_wb_mem_to_reg[0]), .wb_jal(w_wb_jal[0]), .illegal_cnt(w_cnt0));

  pipelined_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(8), .JALR_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(op1), .stall(stall),
    .flush(flush), .freeze(freeze), .id_jump(w_id_jump[1]), .id_jr(w_id_jr[1]),
    .id_reg1(w_id_reg1[1]), .ex_reg_dst(w_ex_reg_dst[1]), .ex_alu_src(w_ex_alu_src[1]),
    .ex_branch(w_ex_branch[1]), .ex_bne(w_ex_bne[1]), .ex_jal(w_ex_jal[1]),
    .ex_illegal(w_ex_illegal[1]), .ex_alu_op(w_alu_op[1]), .ex_mem_read(w_ex_mem_read[1]),
    .mem_read(w_mem_read[1]), .mem_write(w_mem_write[1]), .wb_reg_write(w_wb_reg_write[1]),
    .wb_mem_to_reg(w_wb_mem_to_reg[1]), .wb_jal(w_wb_jal[1]), .illegal_cnt(w_cnt1));

  pipelined_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(2), .JALR_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(op2), .stall(stall),
    .flush(flush), .freeze(freeze), .id_jump(w_id_jump[2]), .id_jr(w_id_jr[2]),
    .id_reg1(w_id_reg1[2]), .ex_reg_dst(w_ex_reg_dst[2]), .ex_alu_src(w_ex_alu_src[2]),
    .ex_branch(w_ex_branch[2]), .ex_bne(w_ex_bne[2]), .ex_jal(w_ex_jal[2]),
    .ex_illegal(w_ex_illegal[2]), .ex_alu_op(w_alu_op[2]), .ex_mem_read(w_ex_mem_read[2]),
    .mem_read(w_mem_read[2]), .mem_write(w_mem_write[2]), .wb_reg_write(w_wb_reg_write[2]),
    .wb_mem_to_reg(w_wb_mem_to_reg[2]), .wb_jal(w_wb_jal[2]), .illegal_cnt(w_cnt2));

  pipelined_control_unit #(.OPCODE_W(8), .ALUOP_W(2), .CNT_W(8), .JALR_EN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(op3), .stall(stall),
    .flush(flush), .freeze(freeze), .id_jump(w_id_jump[3]), .id_jr(w_id_jr[3]),
    .id_reg1(w_id_reg1[3]), .ex_reg_dst(w_ex_reg_dst[3]), .ex_alu_src(w_ex_alu_src[3]),
    .ex_branch(w_ex_branch[3]), .ex_bne(w_ex_bne[3]), .ex_jal(w_ex_jal[3]),
    .ex_illegal(w_ex_illegal[3]), .ex_alu_op(w_alu_op[3]), .ex_mem_read(w_ex_mem_read[3]),
    .mem_read(w_mem_read[3]), .mem_write(w_mem_write[3]), .wb_reg_write(w_wb_reg_write[3]),
    .wb_mem_to_reg(w_wb_mem_to_reg[3]), .wb_jal(w_wb_jal[3]), .illegal_cnt(w_cnt3));

  typedef struct {
    int    cyc;
    int    inst;
    int    fld;
    int    val;
    string tag;
  } exp_t;

  exp_t q[$];
  int   ecount   = 0;
  int   e        = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] getv(input int inst, input int fld);
    case (fld)
      F_JUMP:          return {31'b0, w_id_jump[inst]};
      F_JR:            return {31'b0, w_id_jr[inst]};
      F_REG1:          return {31'b0, w_id_reg1[inst]};
      F_REG_DST:       return {31'b0, w_ex_reg_dst[inst]};
      F_ALU_SRC:       return {31'b0, w_ex_alu_src[inst]};
      F_BRANCH:        return {31'b0, w_ex_branch[inst]};
      F_BNE:           return {31'b0, w_ex_bne[inst]};
      F_EX_JAL:        return {31'b0, w_ex_jal[inst]};
      F_ILLEGAL:       return {31'b0, w_ex_illegal[inst]};
      F_ALU_OP:        return {30'b0, w_alu_op[inst]};
      F_EX_MEM_READ:   return {31'b0, w_ex_mem_read[inst]};
      F_MEM_READ:      return {31'b0, w_mem_read[inst]};
      F_MEM_WRITE:     return {31'b0, w_mem_write[inst]};
      F_WB_REG_WRITE:  return {31'b0, w_wb_reg_write[inst]};
      F_WB_MEM_TO_REG: return {31'b0, w_wb_mem_to_reg[inst]};
      F_WB_JAL:        return {31'b0, w_wb_jal[inst]};
      default: begin
        case (inst)
          0:       return {24'b0, w_cnt0};
          1:       return {24'b0, w_cnt1};
          2:       return {30'b0, w_cnt2};
          default: return {24'b0, w_cnt3};
        endcase
      end
    endcase
  endfunction

  // Drive one ID-stage vector at the falling edge; it is captured by edge e.
  task automatic apply(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                       input logic [7:0] a3, input logic v, input logic st,
                       input logic fl, input logic fz, input logic rn);
    @(negedge clk);
    op0 = a0; op1 = a1; op2 = a2; op3 = a3;
    id_valid = v; stall = st; flush = fl; freeze = fz; rst_n = rn;
    e = ecount + 1;
  endtask

  task automatic op(input logic [5:0] a0);
    apply(a0, OP_R, OP_R, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_at(input int dc, input int inst, input int fld, input int val,
                           input string tag);
    exp_t t;
    t.cyc = e + dc; t.inst = inst; t.fld = fld; t.val = val; t.tag = tag;
    q.push_back(t);
  endtask

  initial begin : monitor
    logic [31:0] got;
    forever begin
      @(posedge clk);
      #1;
      ecount++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= ecount) begin
          checks++;
          got = getv(q[i].inst, q[i].fld);
          if (q[i].cyc != ecount || got !== q[i].val) begin
            failures++;
            $display("FAIL %s: u%0d field %0d got %0d expected %0d (edge %0d, due %0d)",
                     q[i].tag, q[i].inst, q[i].fld, got, q[i].val, ecount, q[i].cyc);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0; freeze = 1'b0;
    op0 = OP_R; op1 = OP_R; op2 = OP_R; op3 = 8'h00;

    apply(OP_R, OP_R, OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(OP_R, OP_R, OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = F_REG_DST; f <= F_CNT; f++) expect_at(0, 0, f, 0, $sformatf("reset_f%0d", f));
    for (int k = 1; k < 4; k++) expect_at(0, k, F_CNT, 0, "reset_cnt");

    // Basic sequence: LW, ADD, SW, BEQ then the remaining opcodes
    op(OP_LW);
    expect_at(0, 0, F_ALU_OP, 0, "lw_aluop"); expect_at(0, 0, F_EX_MEM_READ, 1, "lw_exmr");
    expect_at(1, 0, F_MEM_READ, 1, "lw_memread");
    expect_at(2, 0, F_WB_REG_WRITE, 1, "lw_wbrw"); expect_at(2, 0, F_WB_MEM_TO_REG, 1, "lw_wbm2r");
    op(OP_R);
    expect_at(0, 0, F_ALU_OP, 2, "add_aluop"); expect_at(0, 0, F_REG_DST, 1, "add_regdst");
    expect_at(2, 0, F_WB_REG_WRITE, 1, "add_wbrw"); expect_at(2, 0, F_WB_MEM_TO_REG, 0, "add_wbm2r");
    op(OP_SW);
    expect_at(0, 0, F_ALU_OP, 0, "sw_aluop"); expect_at(0, 0, F_ALU_SRC, 1, "sw_alusrc");
    expect_at(1, 0, F_MEM_WRITE, 1, "sw_memwrite"); expect_at(2, 0, F_WB_REG_WRITE, 0, "sw_wbrw");
    op(OP_BEQ);
    expect_at(0, 0, F_ALU_OP, 1, "beq_aluop"); expect_at(0, 0, F_BRANCH, 1, "beq_branch");
    expect_at(1, 0, F_MEM_WRITE, 0, "beq_memwrite");
    op(OP_BNE);
    expect_at(0, 0, F_BNE, 1, "bne_bne"); expect_at(0, 0, F_ALU_OP, 1, "bne_aluop");
    expect_at(0, 0, F_BRANCH, 0, "bne_branch");
    op(OP_ADDI);
    expect_at(0, 0, F_ALU_SRC, 1, "addi_alusrc"); expect_at(0, 0, F_ALU_OP, 0, "addi_aluop");
    expect_at(2, 0, F_WB_REG_WRITE, 1, "addi_wbrw");
    op(OP_J);
    expect_at(0, 0, F_JUMP, 1, "j_jump"); expect_at(0, 0, F_JR, 0, "j_jr");
    expect_at(0, 0, F_ILLEGAL, 0, "j_illegal");
    op(OP_JR);
    expect_at(0, 0, F_JR, 1, "jr_jr"); expect_at(0, 0, F_REG1, 1, "jr_reg1");
    expect_at(0, 0, F_JUMP, 0, "jr_jump");
    op(OP_JAL);
    expect_at(0, 0, F_JUMP, 1, "jal_jump"); expect_at(0, 0, F_EX_JAL, 1, "jal_exjal");
    expect_at(2, 0, F_WB_JAL, 1, "jal_wbjal"); expect_at(2, 0, F_WB_REG_WRITE, 1, "jal_wbrw");

    // id_valid=0 forces an all-zero, non-illegal bundle
    apply(OP_J, OP_R, OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, 0, F_JUMP, 0, "nv_jump");
    apply(OP_BAD, OP_R, OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, 0, F_ILLEGAL, 0, "nv_illegal"); expect_at(0, 0, F_CNT, 0, "nv_cnt");

    // Load-use stall, flush, and both together
    op(OP_LW);
    expect_at(0, 0, F_EX_MEM_READ, 1, "st_lw_exmr");
    apply(OP_J, OP_R, OP_R, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_at(0, 0, F_JUMP, 1, "st_idjump");
    expect_at(0, 0, F_EX_MEM_READ, 0, "st_bubble_exmr"); expect_at(0, 0, F_ALU_SRC, 0, "st_bubble_alusrc");
    expect_at(0, 0, F_MEM_READ, 1, "st_lw_memread");
    expect_at(1, 0, F_WB_REG_WRITE, 1, "st_lw_wbrw"); expect_at(2, 0, F_WB_REG_WRITE, 0, "st_bubble_wbrw");
    apply(OP_BAD, OP_R, OP_R, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_at(0, 0, F_ILLEGAL, 0, "fl_illegal"); expect_at(0, 0, F_CNT, 0, "fl_cnt");
    apply(OP_R, OP_R, OP_R, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_at(0, 0, F_REG_DST, 0, "stfl_regdst");

    // Freeze with ADD in ID/EX and LW in EX/MEM
    op(OP_LW);
    op(OP_R);
    expect_at(0, 0, F_REG_DST, 1, "pre_fz_regdst"); expect_at(0, 0, F_MEM_READ, 1, "pre_fz_memread");
    for (int k = 0; k < 3; k++) begin
      apply(OP_BAD, OP_R, OP_R, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_at(0, 0, F_REG_DST, 1, "fz_regdst"); expect_at(0, 0, F_MEM_READ, 1, "fz_memread");
      expect_at(0, 0, F_WB_REG_WRITE, 0, "fz_wbrw"); expect_at(0, 0, F_CNT, 0, "fz_cnt");
      expect_at(0, 0, F_ILLEGAL, 0, "fz_illegal");
    end
    op(OP_R);
    expect_at(0, 0, F_REG_DST, 1, "unfz_regdst"); expect_at(0, 0, F_MEM_READ, 0, "unfz_memread");
    expect_at(0, 0, F_WB_REG_WRITE, 1, "unfz_wbrw"); expect_at(0, 0, F_WB_MEM_TO_REG, 1, "unfz_wbm2r");
    op(OP_BAD);
    expect_at(0, 0, F_ILLEGAL, 1, "bad_illegal"); expect_at(0, 0, F_CNT, 1, "bad_cnt");
    expect_at(0, 0, F_REG_DST, 0, "bad_regdst"); expect_at(0, 0, F_JR, 0, "bad_jr");

    // JALR with and without JALR_EN
    apply(OP_JALR, OP_JALR, OP_R, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, 0, F_JR, 1, "jalr_jr"); expect_at(0, 0, F_REG1, 1, "jalr_reg1");
    expect_at(0, 0, F_EX_JAL, 1, "jalr_exjal"); expect_at(0, 0, F_ILLEGAL, 0, "jalr_illegal");
    expect_at(0, 0, F_CNT, 1, "jalr_cnt");
    expect_at(2, 0, F_WB_JAL, 1, "jalr_wbjal"); expect_at(2, 0, F_WB_REG_WRITE, 1, "jalr_wbrw");
    expect_at(0, 1, F_JR, 0, "nojalr_jr"); expect_at(0, 1, F_REG1, 0, "nojalr_reg1");
    expect_at(0, 1, F_ILLEGAL, 1, "nojalr_illegal"); expect_at(0, 1, F_CNT, 1, "nojalr_cnt");
    expect_at(0, 1, F_EX_JAL, 0, "nojalr_exjal");

    // Saturating 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      apply(OP_R, OP_R, OP_BAD2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_at(0, 2, F_CNT, (k > 3) ? 3 : k, $sformatf("sat_cnt_%0d", k));
      expect_at(0, 2, F_ILLEGAL, 1, "sat_illegal");
    end

    // 8-bit opcode: upper bits must be zero
    apply(OP_R, OP_R, OP_R, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, 3, F_ILLEGAL, 0, "w8_lw_illegal"); expect_at(0, 3, F_EX_MEM_READ, 1, "w8_lw_exmr");
    expect_at(1, 3, F_MEM_READ, 1, "w8_lw_memread");
    apply(OP_R, OP_R, OP_R, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_at(0, 3, F_ILLEGAL, 1, "w8_a3_illegal"); expect_at(0, 3, F_EX_MEM_READ, 0, "w8_a3_exmr");
    expect_at(1, 3, F_MEM_READ, 0, "w8_a3_memread"); expect_at(0, 3, F_CNT, 1, "w8_a3_cnt");

    // Reset mid-stream overrides freeze and stall and discards the in-flight LW
    op(OP_LW);
    apply(OP_JAL, OP_R, OP_R, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int f = F_REG_DST; f <= F_CNT; f++) expect_at(0, 0, f, 0, $sformatf("mrst_f%0d", f));
    for (int k = 1; k < 4; k++) expect_at(0, k, F_CNT, 0, "mrst_cnt");
    op(OP_R);
    expect_at(0, 0, F_REG_DST, 1, "post_rst_regdst"); expect_at(0, 0, F_MEM_READ, 0, "post_rst_memread");
    expect_at(0, 0, F_WB_REG_WRITE, 0, "post_rst_wbrw0");
    op(OP_R);
    expect_at(0, 0, F_WB_REG_WRITE, 0, "post_rst_wbrw1");
    op(OP_R);
    expect_at(0, 0, F_WB_REG_WRITE, 1, "post_rst_wbrw2");
    op(OP_R);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into the team's control bundle, then carries each control field through its own pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Supports bubble insertion on stall/flush, a global freeze, an optional JALR mode, and a saturating illegal-opcode counter.
- Sits between the IF/ID register and the datapath. The hazard unit and branch logic drive it.

Parameters:
- OPCODE_W, 6: opcode width. Must be >= 6. Bits above [5:0] must be zero, otherwise the opcode is illegal.
- ALUOP_W, 2: ALUOp width. Must be >= 2. Codes are zero-extended.
- CNT_W, 8: illegal-opcode counter width.
- JALR_EN, 1: when 0, opcode 001111 decodes as illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low
- id_valid  in  1  ID-stage instruction valid
- opcode  in  OPCODE_W  ID-stage opcode
- stall  in  1  load-use stall: ID/EX loads a bubble
- flush  in  1  control-hazard flush: ID/EX loads a bubble
- freeze  in  1  hold every pipeline register
- id_jump, id_jr, id_reg1  out  1  combinational ID-stage decode, qualified by id_valid
- ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_jal, ex_illegal  out  1  ID/EX register outputs
- ex_alu_op  out  ALUOP_W  ID/EX register output
- ex_mem_read  out  1  ID/EX MemRead, used for load-use detection
- mem_read, mem_write  out  1  EX/MEM register outputs
- wb_reg_write, wb_mem_to_reg, wb_jal  out  1  MEM/WB register outputs
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Decode table (low 6 bits). Fields: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, bne, ALUOp, Jump, jr, reg1, jal.
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=2.
  - 100011 LW: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=0.
  - 101011 SW: ALUSrc=1, MemWrite=1, ALUOp=0.
  - 000100 BEQ: Branch=1, ALUOp=1.
  - 100000 BNE: bne=1, ALUOp=1.
  - 000001 ADDI: ALUSrc=1, RegWrite=1, ALUOp=0.
  - 000010 J: Jump=1.
  - 000011 JR: jr=1, reg1=1.
  - 000111 JAL: Jump=1, jal=1, RegWrite=1.
  - 001111 JALR (only when JALR_EN=1): jr=1, reg1=1, jal=1, RegWrite=1.
  - Any other opcode: all fields 0, illegal=1.
  - Fields not listed for an opcode are 0.
- When id_valid=0, the decoded bundle is forced to all zeros and illegal=0.
- id_jump/id_jr/id_reg1 are combinational with 0-cycle latency. They are not gated by stall; the PC logic owns that gating.
- Reset (rst_n=0 at a clock edge): every registered output goes to 0, including illegal_cnt. Reset overrides freeze, stall and flush. Reset mid-pipeline discards all in-flight bundles.
- Priority at each edge: reset > freeze > (stall | flush) > normal.
- freeze=1: all three stage registers and illegal_cnt hold their values.
- stall=1 or flush=1 (and freeze=0):
  - ID/EX loads the all-zero bubble, so ex_illegal=0.
  - EX/MEM and MEM/WB advance normally.
  - Stall and flush asserted together behave the same as either one alone.
- Normal operation: ID/EX <= decode; EX/MEM <= the MEM/WB-relevant fields of ID/EX; MEM/WB <= the WB fields of EX/MEM.
- Field latency from the opcode edge: EX fields 1 cycle, MEM fields 2 cycles, WB fields 3 cycles.
- illegal_cnt increments by 1 on an edge where id_valid & illegal & !stall & !flush & !freeze. It saturates at 2^CNT_W-1 and never wraps.
- ALUOp width rule: the 2-bit code is zero-extended to ALUOP_W.

Test Plan:
1. Reset, then id_valid=1 with opcode sequence LW, ADD(000000), SW, BEQ -> ex_alu_op=0,2,0,1 on cycles 1-4. mem_read=1 at cycle 2. mem_write=1 at cycle 4. wb_reg_write=1 and wb_mem_to_reg=1 at cycle 3. wb_reg_write=1 at cycle 4.
2. LW at cycle 0 with stall=1 at cycle 1 -> ex_mem_read=1 at cycle 1; bubble at cycle 2 (all ex_* = 0). The LW continues, giving mem_read=1 at cycle 2 and wb_reg_write=1 at cycle 3.
3. freeze=1 for 3 cycles with ADD in ID/EX and LW in EX/MEM -> ex_reg_dst=1 and mem_read=1 hold unchanged. illegal_cnt is unchanged even if opcode=111111.
4. JALR_EN=0 instance, opcode 001111 -> id_jr=0, ex_illegal=1 after 1 cycle, illegal_cnt=1. The JALR_EN=1 instance gives id_jr=1, id_reg1=1, wb_jal=1 at cycle 3.
5. CNT_W=2 instance, 5 consecutive illegal opcodes (e.g. 010101) -> illegal_cnt goes 1, 2, 3, 3, 3.
6. OPCODE_W=8 instance, opcode 8'h23 (LW) vs 8'hA3 -> 8'h23 gives mem_read=1 at cycle 2; 8'hA3 gives ex_illegal=1 and mem_read=0. rst_n=0 asserted mid-stream clears all outputs on the next edge.
